// File: rtl/agc_io_register_file.sv
// AGC I/O channel register file: channel 0 reads zero, channels 1-7 are live
// external inputs, and channels 8-31 are core-writable storage.
module agc_io_register_file #(
    parameter int DATA_W = 15,
    parameter int SEL_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SEL_W-1:0]  sel_read,
    output logic [DATA_W-1:0] data_read,
    input  logic              en_write,
    input  logic [SEL_W-1:0]  sel_write,
    input  logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_DSKY_VERB,
    input  logic [DATA_W-1:0] data_DSKY_NOUN,
    input  logic [DATA_W-1:0] data_AXI_G,
    input  logic [DATA_W-1:0] data_AXI_M,
    input  logic [DATA_W-1:0] data_AXI_RA,
    input  logic [DATA_W-1:0] data_AXI_RB,
    input  logic [DATA_W-1:0] data_AXI_ATX,
    output logic [DATA_W-1:0] dsky_display,
    output logic [DATA_W-1:0] axi_command,
    output logic              write_strobe
);

    localparam int              NUM_CH    = 1 << SEL_W;
    localparam logic [SEL_W-1:0] FIRST_REG = SEL_W'(8);

    logic [DATA_W-1:0] regs [8:NUM_CH-1];
    logic              write_ok;

    // Only channels 8 and up hold storage; writes below that are dropped.
    assign write_ok = en_write && (sel_write >= FIRST_REG);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 8; i < NUM_CH; i++) begin
                regs[i] <= '0;
            end
            write_strobe <= 1'b0;
        end else begin
            if (write_ok) begin
                regs[sel_write] <= data_write;
            end
            write_strobe <= write_ok;
        end
    end

    always_comb begin
        data_read = '0;
        case (sel_read)
            SEL_W'(0): data_read = '0;
            SEL_W'(1): data_read = data_DSKY_VERB;
            SEL_W'(2): data_read = data_DSKY_NOUN;
            SEL_W'(3): data_read = data_AXI_G;
            SEL_W'(4): data_read = data_AXI_M;
            SEL_W'(5): data_read = data_AXI_RA;
            SEL_W'(6): data_read = data_AXI_RB;
            SEL_W'(7): data_read = data_AXI_ATX;
            default:   data_read = regs[sel_read];
        endcase
    end

    assign dsky_display = regs[8];
    assign axi_command  = regs[9];

endmodule

// File: tb/tb_agc_io_register_file.sv
// Directed self-checking bench for agc_io_register_file; each task covers one
// feature and compares against hand-computed values.
module tb_agc_io_register_file;

    logic        clock;
    logic        reset;
    logic [4:0]  sel_read;
    logic [14:0] data_read;
    logic        en_write;
    logic [4:0]  sel_write;
    logic [14:0] data_write;
    logic [14:0] data_DSKY_VERB;
    logic [14:0] data_DSKY_NOUN;
    logic [14:0] data_AXI_G;
    logic [14:0] data_AXI_M;
    logic [14:0] data_AXI_RA;
    logic [14:0] data_AXI_RB;
    logic [14:0] data_AXI_ATX;
    logic [14:0] dsky_display;
    logic [14:0] axi_command;
    logic        write_strobe;

    int errors = 0;
    int checks = 0;

    agc_io_register_file #(.DATA_W(15), .SEL_W(5)) dut (
        .clock(clock),
        .reset(reset),
        .sel_read(sel_read),
        .data_read(data_read),
        .en_write(en_write),
        .sel_write(sel_write),
        .data_write(data_write),
        .data_DSKY_VERB(data_DSKY_VERB),
        .data_DSKY_NOUN(data_DSKY_NOUN),
        .data_AXI_G(data_AXI_G),
        .data_AXI_M(data_AXI_M),
        .data_AXI_RA(data_AXI_RA),
        .data_AXI_RB(data_AXI_RB),
        .data_AXI_ATX(data_AXI_ATX),
        .dsky_display(dsky_display),
        .axi_command(axi_command),
        .write_strobe(write_strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [14:0] expected_input(input int ch);
        case (ch)
            1: return 15'd37;
            2: return 15'd5;
            3: return 15'b001010010000011;
            4: return 15'b010000111010010;
            5: return 15'b111110000000010;
            default: return 15'd0;
        endcase
    endfunction

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        en_write = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (write_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobe got=%b want=0", write_strobe);
        end
        checks++;
        if (dsky_display !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_dsky got=%h want=0", dsky_display);
        end
        checks++;
        if (axi_command !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_axi got=%h want=0", axi_command);
        end
    endtask

    task automatic test_read_sweep();
        for (int ch = 0; ch < 32; ch++) begin
            sel_read = 5'(ch);
            #1;
            checks++;
            if (data_read !== expected_input(ch)) begin
                errors++;
                $display("[TB] FAIL sweep_ch%0d got=%h want=%h", ch, data_read, expected_input(ch));
            end
        end
    endtask

    task automatic test_write_basic();
        @(negedge clock);
        en_write = 1'b1;
        sel_write = 5'd8;
        data_write = 15'h1234;
        #1;
        checks++;
        if (dsky_display !== 15'd0) begin
            errors++;
            $display("[TB] FAIL dsky_before_edge got=%h want=0", dsky_display);
        end
        @(posedge clock); #1;
        checks++;
        if (dsky_display !== 15'h1234) begin
            errors++;
            $display("[TB] FAIL dsky_after_write got=%h want=1234", dsky_display);
        end
        checks++;
        if (write_strobe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL strobe_write8 got=%b want=1", write_strobe);
        end
        sel_write = 5'd31;
        data_write = 15'h7FFF;
        @(posedge clock); #1;
        en_write = 1'b0;
        checks++;
        if (write_strobe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL strobe_back_to_back got=%b want=1", write_strobe);
        end
        @(posedge clock); #1;
        checks++;
        if (write_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL strobe_idle got=%b want=0", write_strobe);
        end
        sel_read = 5'd8;
        #1;
        checks++;
        if (data_read !== 15'h1234) begin
            errors++;
            $display("[TB] FAIL read_ch8 got=%h want=1234", data_read);
        end
        sel_read = 5'd31;
        #1;
        checks++;
        if (data_read !== 15'h7FFF) begin
            errors++;
            $display("[TB] FAIL read_ch31 got=%h want=7fff", data_read);
        end
    endtask

    task automatic test_write_readonly();
        @(negedge clock);
        en_write = 1'b1;
        sel_write = 5'd3;
        data_write = 15'h5555;
        sel_read = 5'd3;
        @(posedge clock); #1;
        en_write = 1'b0;
        checks++;
        if (write_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL readonly_strobe got=%b want=0", write_strobe);
        end
        checks++;
        if (data_read !== 15'b001010010000011) begin
            errors++;
            $display("[TB] FAIL readonly_ch3 got=%h want=%h", data_read, 15'b001010010000011);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clock);
        sel_read = 5'd9;
        en_write = 1'b1;
        sel_write = 5'd9;
        data_write = 15'h00AA;
        #1;
        checks++;
        if (data_read !== 15'd0) begin
            errors++;
            $display("[TB] FAIL same_cycle_old got=%h want=0", data_read);
        end
        @(posedge clock); #1;
        en_write = 1'b0;
        checks++;
        if (data_read !== 15'h00AA) begin
            errors++;
            $display("[TB] FAIL same_cycle_new got=%h want=00aa", data_read);
        end
        checks++;
        if (axi_command !== 15'h00AA) begin
            errors++;
            $display("[TB] FAIL axi_command got=%h want=00aa", axi_command);
        end
    endtask

    task automatic test_reset_priority();
        for (int ch = 8; ch < 32; ch++) begin
            @(negedge clock);
            en_write = 1'b1;
            sel_write = 5'(ch);
            data_write = 15'(ch + 100);
        end
        @(negedge clock);
        en_write = 1'b0;
        sel_read = 5'd10;
        #1;
        checks++;
        if (data_read !== 15'd110) begin
            errors++;
            $display("[TB] FAIL fill_ch10 got=%h want=%h", data_read, 15'd110);
        end
        @(negedge clock);
        reset = 1'b1;
        en_write = 1'b1;
        sel_write = 5'd10;
        data_write = 15'h0001;
        @(posedge clock); #1;
        reset = 1'b0;
        en_write = 1'b0;
        checks++;
        if (write_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_prio_strobe got=%b want=0", write_strobe);
        end
        for (int ch = 8; ch < 32; ch++) begin
            sel_read = 5'(ch);
            #1;
            checks++;
            if (data_read !== 15'd0) begin
                errors++;
                $display("[TB] FAIL reset_prio_ch%0d got=%h want=0", ch, data_read);
            end
        end
        checks++;
        if (dsky_display !== 15'd0 || axi_command !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_prio_outs dsky=%h axi=%h want=0", dsky_display, axi_command);
        end
    endtask

    task automatic test_comb_follow();
        @(negedge clock);
        sel_read = 5'd2;
        #1;
        data_DSKY_NOUN = 15'h2A5C;
        #1;
        checks++;
        if (data_read !== 15'h2A5C) begin
            errors++;
            $display("[TB] FAIL noun_follow got=%h want=2a5c", data_read);
        end
        data_DSKY_NOUN = 15'h0013;
        #1;
        checks++;
        if (data_read !== 15'h0013) begin
            errors++;
            $display("[TB] FAIL noun_follow2 got=%h want=0013", data_read);
        end
    endtask

    initial begin
        reset = 1'b1;
        en_write = 1'b0;
        sel_read = 5'd0;
        sel_write = 5'd0;
        data_write = 15'd0;
        data_DSKY_VERB = 15'd37;
        data_DSKY_NOUN = 15'd5;
        data_AXI_G = 15'b001010010000011;
        data_AXI_M = 15'b010000111010010;
        data_AXI_RA = 15'b111110000000010;
        data_AXI_RB = 15'd0;
        data_AXI_ATX = 15'd0;
        test_reset();
        test_read_sweep();
        test_write_basic();
        test_write_readonly();
        test_same_cycle();
        test_reset_priority();
        test_comb_follow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
